// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq
//  Description : Program-counter sequencer for the nRISC core. Holds the PC
//                register and selects the next PC from sequential increment,
//                relative branch, absolute jump, call and return. Includes a
//                small circular hardware return-address stack (RAS).
//
//  Ports
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    stall        in   hold PC, RAS and flags this cycle
//    branch       in   take relative branch (pc + sext(branch_off))
//    branch_off   in   [OFF_W] signed two's-complement branch offset
//    jump         in   absolute jump to jump_addr
//    call         in   push pc+STEP, go to jump_addr
//    ret          in   pop return address into pc
//    jump_addr    in   [W] absolute target for jump/call
//    pc           out  [W] registered current PC
//    pc_inc       out  [W] pc + STEP (combinational)
//    ras_empty    out  RAS holds no entries
//    ras_full     out  RAS holds RAS_DEPTH entries
//    ras_ovf      out  sticky: call issued while RAS full
//    ras_unf      out  sticky: ret issued while RAS empty
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_seq #(
    parameter int          W         = 8,
    parameter int          STEP      = 1,
    parameter int          OFF_W     = 5,
    parameter int unsigned RESET_VEC = 0,
    parameter int          RAS_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             stall,
    input  wire logic             branch,
    input  wire logic [OFF_W-1:0] branch_off,
    input  wire logic             jump,
    input  wire logic             call,
    input  wire logic             ret,
    input  wire logic [W-1:0]     jump_addr,
    output logic      [W-1:0]     pc,
    output logic      [W-1:0]     pc_inc,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_ovf,
    output logic                  ras_unf
);

    localparam int               PTR_W       = $clog2(RAS_DEPTH);
    localparam logic [W-1:0]     c_step      = W'(STEP);
    localparam logic [W-1:0]     c_reset_vec = W'(RESET_VEC);
    localparam logic [PTR_W:0]   c_depth     = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one   = 1;
    localparam logic [PTR_W-1:0] c_ptr_one   = 1;

    logic [W-1:0]     r_pc;
    logic [W-1:0]     r_ras [RAS_DEPTH];
    // r_wp is the slot the next push writes; the top entry sits at r_wp-1.
    // When full, r_wp points at the oldest entry, so a push overwrites it.
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W:0]   r_cnt;
    logic             r_ovf;
    logic             r_unf;

    logic [W-1:0]     w_pc_inc;
    logic [W-1:0]     w_off_ext;
    logic [W-1:0]     w_br_tgt;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_push;

    generate
        if (W > OFF_W) begin : g_sext_ext
            assign w_off_ext = {{(W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
        end else begin : g_sext_trunc
            assign w_off_ext = branch_off[W-1:0];
        end
    endgenerate

    assign w_pc_inc  = r_pc + c_step;
    assign w_br_tgt  = r_pc + w_off_ext;
    assign w_top_idx = r_wp - c_ptr_one;
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == c_depth);
    // ret outranks call, so a simultaneous call+ret never pushes
    assign w_push    = !stall && !ret && call;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= c_reset_vec;
            r_wp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (!w_empty) begin
                    r_pc  <= r_ras[w_top_idx];
                    r_wp  <= w_top_idx;
                    r_cnt <= r_cnt - c_cnt_one;
                end else begin
                    r_pc  <= w_pc_inc;
                    r_unf <= 1'b1;
                end
            end else if (call) begin
                r_pc <= jump_addr;
                r_wp <= r_wp + c_ptr_one;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else if (jump) begin
                r_pc <= jump_addr;
            end else if (branch) begin
                r_pc <= w_br_tgt;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    // Stack storage carries no reset: contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_wp] <= w_pc_inc;
        end
    end

    assign pc        = r_pc;
    assign pc_inc    = w_pc_inc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_seq
//  Description : Self-checking bench for pc_seq (W=8, STEP=1, OFF_W=5,
//                RESET_VEC=0x10, RAS_DEPTH=4). A queue-based reference model
//                tracks the PC and return stack; a compare process checks
//                every output on each falling edge, and directed sequences
//                pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

    localparam int W     = 8;
    localparam int OFF_W = 5;
    localparam int DEPTH = 4;
    localparam int RVEC  = 'h10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             stall = 1'b0;
    logic             branch = 1'b0;
    logic [OFF_W-1:0] branch_off = '0;
    logic             jump = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [W-1:0]     jump_addr = '0;
    logic [W-1:0]     pc;
    logic [W-1:0]     pc_inc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    int total = 0;
    int bad   = 0;
    bit en    = 1'b0;

    pc_seq #(
        .W         (W),
        .STEP      (1),
        .OFF_W     (OFF_W),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch     (branch),
        .branch_off (branch_off),
        .jump       (jump),
        .call       (call),
        .ret        (ret),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .pc_inc     (pc_inc),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_pc;
    int         m_stack[$];
    bit         m_ovf;
    bit         m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RVEC;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc  = (m_pc + 1) % 256;
                    m_unf = 1'b1;
                end
            end else if (call) begin
                m_stack.push_back((m_pc + 1) % 256);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = int'(jump_addr);
            end else if (jump) begin
                m_pc = int'(jump_addr);
            end else if (branch) begin
                m_pc = (m_pc + int'($signed(branch_off)) + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (en) begin
            chk("model_pc",    int'(pc),        m_pc);
            chk("model_inc",   int'(pc_inc),    (m_pc + 1) % 256);
            chk("model_empty", int'(ras_empty), int'(m_stack.size() == 0));
            chk("model_full",  int'(ras_full),  int'(m_stack.size() == DEPTH));
            chk("model_ovf",   int'(ras_ovf),   int'(m_ovf));
            chk("model_unf",   int'(ras_unf),   int'(m_unf));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply one request, let it take effect on the next rising edge, return #1 after.
    task automatic go(input bit s, input bit b, input logic [4:0] o,
                      input bit j, input bit c, input bit r, input int a);
        stall = s; branch = b; branch_off = o;
        jump = j; call = c; ret = r; jump_addr = W'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        go(0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    // Mid-cycle asynchronous reset with immediate checks; releases on the next falling edge.
    task automatic pulse_reset();
        stall = 0; branch = 0; jump = 0; call = 0; ret = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_pc",    int'(pc),        RVEC);
        chk("rst_empty", int'(ras_empty), 1);
        chk("rst_full",  int'(ras_full),  0);
        chk("rst_ovf",   int'(ras_ovf),   0);
        chk("rst_unf",   int'(ras_unf),   0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        pulse_reset();
        en = 1'b1;

        // reset then increment
        idle(); chk("inc1", int'(pc), 'h11);
        idle(); chk("inc2", int'(pc), 'h12);
        idle(); chk("inc3", int'(pc), 'h13);

        // wrap
        go(0, 0, 5'd0, 1, 0, 0, 'hFE); chk("jmp_fe", int'(pc), 'hFE);
        idle(); chk("wrap_ff", int'(pc), 'hFF);
        idle(); chk("wrap_00", int'(pc), 'h00);
        chk("wrap_inc", int'(pc_inc), 'h01);

        // branches
        go(0, 0, 5'd0, 1, 0, 0, 'h20);
        go(0, 1, 5'b11101, 0, 0, 0, 0); chk("br_m3",  int'(pc), 'h1D);
        go(0, 1, 5'b01111, 0, 0, 0, 0); chk("br_p15", int'(pc), 'h2C);
        go(0, 0, 5'd0, 1, 0, 0, 'hFD);
        go(0, 1, 5'd5, 0, 0, 0, 0);     chk("br_wrap", int'(pc), 'h02);

        // stall and priority
        go(0, 0, 5'd0, 1, 0, 0, 'h40);
        go(1, 0, 5'd0, 1, 0, 0, 'h80); chk("stall", int'(pc), 'h40);
        go(0, 1, 5'd3, 1, 0, 0, 'h80); chk("jmp_over_br", int'(pc), 'h80);

        // call/return nesting
        go(0, 0, 5'd0, 1, 0, 0, 'h05);
        go(0, 0, 5'd0, 0, 1, 0, 'h50); chk("call1", int'(pc), 'h50);
        go(0, 0, 5'd0, 0, 1, 0, 'h70); chk("call2", int'(pc), 'h70);
        go(0, 0, 5'd0, 0, 1, 1, 'h99); chk("ret1",  int'(pc), 'h51);
        go(0, 0, 5'd0, 0, 0, 1, 0);    chk("ret2",  int'(pc), 'h06);
        chk("nest_empty", int'(ras_empty), 1);
        chk("nest_flags", int'({ras_ovf, ras_unf}), 0);

        // overflow
        go(0, 0, 5'd0, 1, 0, 0, 'h00);
        for (int i = 1; i <= 5; i++) go(0, 0, 5'd0, 0, 1, 0, i * 'h10);
        chk("ovf_pc",   int'(pc),       'h50);
        chk("ovf_full", int'(ras_full), 1);
        chk("ovf_flag", int'(ras_ovf),  1);
        go(0, 0, 5'd0, 0, 0, 1, 0); chk("oret1", int'(pc), 'h41);
        go(0, 0, 5'd0, 0, 0, 1, 0); chk("oret2", int'(pc), 'h31);
        go(0, 0, 5'd0, 0, 0, 1, 0); chk("oret3", int'(pc), 'h21);
        go(0, 0, 5'd0, 0, 0, 1, 0); chk("oret4", int'(pc), 'h11);
        chk("ovf_empty", int'(ras_empty), 1);

        // underflow, stickiness, reset mid-operation
        go(0, 0, 5'd0, 1, 0, 0, 'h33);
        go(0, 0, 5'd0, 0, 0, 1, 0); chk("unf_pc", int'(pc), 'h34);
        chk("unf_flag", int'(ras_unf), 1);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("unf_sticky", int'(ras_unf), 1);
        end
        go(0, 0, 5'd0, 0, 1, 0, 'h60);
        go(0, 0, 5'd0, 0, 1, 0, 'h70);
        chk("two_pushed", int'(ras_empty), 0);
        pulse_reset();
        go(0, 0, 5'd0, 0, 0, 1, 0);
        chk("post_rst_pc",  int'(pc),      RVEC + 1);
        chk("post_rst_unf", int'(ras_unf), 1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            go($urandom_range(0, 7) == 0,
               $urandom_range(0, 2) == 0,
               5'($urandom),
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,
               int'($urandom_range(0, 255)));
        end

        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
